quic_hdr_parser: RTL and testbench

QUIC_HDR_PARSER -- requirements
Module: quic_hdr_parser

---
 rtl/quic_hdr_parser.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_quic_hdr_parser.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/quic_hdr_parser.sv
// quic_hdr_parser: byte-serial QUIC packet header parser.
// Accepts one byte per cycle while in_valid is high and extracts the long-header fields
// (version check, DCID/SCID, token length, payload length) or short-header DCID.
// Field outputs are registered and stay stable from the hdr_valid pulse until the
// first byte of the next packet.
//
// Optional feature: define QUIC_SHORT_HDR_EN to parse short-header packets; otherwise a
// first byte with bit7=0 is rejected with err_code 5.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   in_valid/in_data/in_last byte stream; in_last marks the final byte of a packet
//   hdr_valid                one-cycle pulse when the header is complete
//   hdr_long/hdr_type/pn_len first-byte derived fields
//   dcid_len/scid_len        connection ID lengths in bytes
//   dcid/scid                connection IDs, first byte in MSBs, zero padded
//   token_len/payload_len    decoded variable-length integers
//   err/err_code             one-cycle error pulse; cause held until next packet
//   busy                     high while a packet is being consumed
module quic_hdr_parser #(
   parameter int unsigned MAX_CID_LEN    = 20,
   parameter int unsigned SHORT_DCID_LEN = 8,
   parameter logic [31:0] VERSION        = 32'h0000_0001,
   localparam int unsigned CLW = $clog2(MAX_CID_LEN + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [7:0]               in_data,
   input  logic                     in_last,
   output logic                     hdr_valid,
   output logic                     hdr_long,
   output logic [1:0]               hdr_type,
   output logic [1:0]               pn_len,
   output logic [CLW-1:0]           dcid_len,
   output logic [CLW-1:0]           scid_len,
   output logic [8*MAX_CID_LEN-1:0] dcid,
   output logic [8*MAX_CID_LEN-1:0] scid,
   output logic [61:0]              token_len,
   output logic [61:0]              payload_len,
   output logic                     err,
   output logic [2:0]               err_code,
   output logic                     busy
);

   localparam logic [7:0]     MaxCid8  = 8'(MAX_CID_LEN);
   localparam logic [CLW-1:0] ShortLen = CLW'(SHORT_DCID_LEN);

   typedef enum logic [3:0] {
      StIdle, StVer, StDcil, StDcid, StScil, StScid, StTokl, StTok, StLen,
`ifdef QUIC_SHORT_HDR_EN
      StSdcid,
`endif
      StPayload, StDrain
   } state_e;

   state_e                   state_q, state_d;
   logic [4:0]               cnt_q, cnt_d;       // CID byte index / var-int bytes remaining
   logic [23:0]              ver_q, ver_d;
   logic [61:0]              tok_rem_q, tok_rem_d;
   logic                     hdr_valid_q, hdr_valid_d, err_q, err_d;
   logic                     hdr_long_q, hdr_long_d;
   logic [1:0]               hdr_type_q, hdr_type_d, pn_len_q, pn_len_d;
   logic [CLW-1:0]           dcid_len_q, dcid_len_d, scid_len_q, scid_len_d;
   logic [8*MAX_CID_LEN-1:0] dcid_q, dcid_d, scid_q, scid_d;
   logic [61:0]              token_len_q, token_len_d, payload_len_q, payload_len_d;
   logic [2:0]               err_code_q, err_code_d;

   logic       done, fail, scid_end, vi_done;
   logic [2:0] code;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      ver_d         = ver_q;
      tok_rem_d     = tok_rem_q;
      hdr_valid_d   = 1'b0;
      err_d         = 1'b0;
      hdr_long_d    = hdr_long_q;
      hdr_type_d    = hdr_type_q;
      pn_len_d      = pn_len_q;
      dcid_len_d    = dcid_len_q;
      scid_len_d    = scid_len_q;
      dcid_d        = dcid_q;
      scid_d        = scid_q;
      token_len_d   = token_len_q;
      payload_len_d = payload_len_q;
      err_code_d    = err_code_q;
      done          = 1'b0;
      fail          = 1'b0;
      scid_end      = 1'b0;
      vi_done       = 1'b0;
      code          = 3'd0;
      if (in_valid) begin
         unique case (state_q)
            StIdle: begin
               // New packet: previous fields are released here.
               hdr_long_d    = in_data[7];
               hdr_type_d    = 2'd0;
               pn_len_d      = in_data[1:0];
               dcid_len_d    = '0;
               scid_len_d    = '0;
               dcid_d        = '0;
               scid_d        = '0;
               token_len_d   = '0;
               payload_len_d = '0;
               err_code_d    = 3'd0;
               cnt_d         = 5'd0;
               if (!in_data[6]) begin
                  fail = 1'b1;
                  code = 3'd1;
               end else if (in_data[7]) begin
                  hdr_type_d = in_data[5:4];
                  state_d    = StVer;
               end else begin
                  dcid_len_d = ShortLen;
`ifdef QUIC_SHORT_HDR_EN
                  if (SHORT_DCID_LEN == 0) done = 1'b1;
                  else state_d = StSdcid;
`else
                  fail = 1'b1;
                  code = 3'd5;
`endif
               end
            end
            StVer: begin
               ver_d = {ver_q[15:0], in_data};
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd3) begin
                  cnt_d = 5'd0;
                  if ({ver_q, in_data} != VERSION) begin
                     fail = 1'b1;
                     code = 3'd2;
                  end else begin
                     state_d = StDcil;
                  end
               end
            end
            StDcil: begin
               if (in_data > MaxCid8) begin
                  fail = 1'b1;
                  code = 3'd3;
               end else begin
                  dcid_len_d = in_data[CLW-1:0];
                  state_d    = (in_data == 8'd0) ? StScil : StDcid;
               end
            end
            StDcid: begin
               dcid_d[8*(MAX_CID_LEN-1-32'(cnt_q)) +: 8] = in_data;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'(dcid_len_q) - 5'd1) begin
                  cnt_d   = 5'd0;
                  state_d = StScil;
               end
            end
            StScil: begin
               if (in_data > MaxCid8) begin
                  fail = 1'b1;
                  code = 3'd3;
               end else begin
                  scid_len_d = in_data[CLW-1:0];
                  if (in_data == 8'd0) scid_end = 1'b1;
                  else state_d = StScid;
               end
            end
            StScid: begin
               scid_d[8*(MAX_CID_LEN-1-32'(cnt_q)) +: 8] = in_data;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'(scid_len_q) - 5'd1) begin
                  cnt_d    = 5'd0;
                  scid_end = 1'b1;
               end
            end
            StTokl: begin
               // cnt_q == 0 marks the var-int prefix byte; otherwise bytes still to come.
               if (cnt_q == 5'd0) begin
                  token_len_d = {56'd0, in_data[5:0]};
                  cnt_d       = (5'd1 << in_data[7:6]) - 5'd1;
                  vi_done     = (in_data[7:6] == 2'd0);
               end else begin
                  token_len_d = {token_len_q[53:0], in_data};
                  cnt_d       = cnt_q - 5'd1;
                  vi_done     = (cnt_q == 5'd1);
               end
               if (vi_done) begin
                  tok_rem_d = token_len_d;
                  state_d   = (token_len_d == 62'd0) ? StLen : StTok;
               end
            end
            StTok: begin
               tok_rem_d = tok_rem_q - 62'd1;
               if (tok_rem_q == 62'd1) state_d = StLen;
            end
            StLen: begin
               if (cnt_q == 5'd0) begin
                  payload_len_d = {56'd0, in_data[5:0]};
                  cnt_d         = (5'd1 << in_data[7:6]) - 5'd1;
                  done          = (in_data[7:6] == 2'd0);
               end else begin
                  payload_len_d = {payload_len_q[53:0], in_data};
                  cnt_d         = cnt_q - 5'd1;
                  done          = (cnt_q == 5'd1);
               end
            end
`ifdef QUIC_SHORT_HDR_EN
            StSdcid: begin
               dcid_d[8*(MAX_CID_LEN-1-32'(cnt_q)) +: 8] = in_data;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'(ShortLen) - 5'd1) begin
                  cnt_d = 5'd0;
                  done  = 1'b1;
               end
            end
`endif
            default: ;  // StPayload / StDrain: discard bytes until in_last
         endcase

         if (scid_end) begin
            if (hdr_type_q == 2'd3) done = 1'b1;      // Retry: no token or length
            else if (hdr_type_q == 2'd0) state_d = StTokl;
            else state_d = StLen;
         end

         if (fail) begin
            err_d      = 1'b1;
            err_code_d = code;
            state_d    = in_last ? StIdle : StDrain;
         end else if (done) begin
            hdr_valid_d = 1'b1;
            state_d     = in_last ? StIdle : StPayload;
         end else if (in_last) begin
            if (state_q != StPayload && state_q != StDrain) begin
               err_d      = 1'b1;
               err_code_d = 3'd4;                    // truncated header
            end
            state_d = StIdle;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         ver_q         <= '0;
         tok_rem_q     <= '0;
         hdr_valid_q   <= 1'b0;
         err_q         <= 1'b0;
         hdr_long_q    <= 1'b0;
         hdr_type_q    <= '0;
         pn_len_q      <= '0;
         dcid_len_q    <= '0;
         scid_len_q    <= '0;
         dcid_q        <= '0;
         scid_q        <= '0;
         token_len_q   <= '0;
         payload_len_q <= '0;
         err_code_q    <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         ver_q         <= ver_d;
         tok_rem_q     <= tok_rem_d;
         hdr_valid_q   <= hdr_valid_d;
         err_q         <= err_d;
         hdr_long_q    <= hdr_long_d;
         hdr_type_q    <= hdr_type_d;
         pn_len_q      <= pn_len_d;
         dcid_len_q    <= dcid_len_d;
         scid_len_q    <= scid_len_d;
         dcid_q        <= dcid_d;
         scid_q        <= scid_d;
         token_len_q   <= token_len_d;
         payload_len_q <= payload_len_d;
         err_code_q    <= err_code_d;
      end
   end

   assign hdr_valid   = hdr_valid_q;
   assign err         = err_q;
   assign hdr_long    = hdr_long_q;
   assign hdr_type    = hdr_type_q;
   assign pn_len      = pn_len_q;
   assign dcid_len    = dcid_len_q;
   assign scid_len    = scid_len_q;
   assign dcid        = dcid_q;
   assign scid        = scid_q;
   assign token_len   = token_len_q;
   assign payload_len = payload_len_q;
   assign err_code    = err_code_q;
   assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_quic_hdr_parser.sv
// tb_quic_hdr_parser: directed self-checking bench for quic_hdr_parser (default parameters).
// Each packet is streamed byte by byte; the byte index after which hdr_valid / err pulse
// is recorded and compared with hand-computed expectations, along with the field outputs.
module tb_quic_hdr_parser;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic [7:0]   in_data = 8'd0;
   logic         in_last = 1'b0;
   logic         hdr_valid, hdr_long, err, busy;
   logic [1:0]   hdr_type, pn_len;
   logic [4:0]   dcid_len, scid_len;
   logic [159:0] dcid, scid;
   logic [61:0]  token_len, payload_len;
   logic [2:0]   err_code;

   quic_hdr_parser dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .hdr_valid(hdr_valid), .hdr_long(hdr_long), .hdr_type(hdr_type), .pn_len(pn_len),
      .dcid_len(dcid_len), .scid_len(scid_len), .dcid(dcid), .scid(scid),
      .token_len(token_len), .payload_len(payload_len), .err(err), .err_code(err_code),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic [7:0] pkt[$];
   int hv_idx, err_idx, hv_n, err_n;
   logic busy_at_err, busy_after_hv, both_seen = 1'b0;

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) if (hdr_valid && err) both_seen = 1'b1;

   // Stream pkt; in_last on its final byte; 'gap' idle cycles after every byte.
   task automatic send_pkt(input int gap);
      hv_idx = -1; err_idx = -1; hv_n = 0; err_n = 0;
      busy_at_err = 1'b0; busy_after_hv = 1'b0;
      for (int i = 0; i < pkt.size(); i++) begin
         in_valid = 1'b1;
         in_data  = pkt[i];
         in_last  = (i == pkt.size() - 1);
         @(posedge clk); #1;
         if (hdr_valid) begin hv_idx = i; hv_n++; busy_after_hv = busy; end
         if (err) begin err_idx = i; err_n++; busy_at_err = busy; end
         in_valid = 1'b0;
         in_last  = 1'b0;
         repeat (gap) begin @(posedge clk); #1; end
      end
   endtask

   task automatic build_initial(input logic [7:0] ver_lsb);
      pkt = {};
      pkt.push_back(8'hC3);
      pkt.push_back(8'h00); pkt.push_back(8'h00); pkt.push_back(8'h00);
      pkt.push_back(ver_lsb);
      pkt.push_back(8'h08);
      for (int i = 0; i < 8; i++) pkt.push_back(8'h11 + 8'(i));
      pkt.push_back(8'h08);
      for (int i = 0; i < 8; i++) pkt.push_back(8'h21 + 8'(i));
      pkt.push_back(8'h00);
      pkt.push_back(8'h41); pkt.push_back(8'h2C);
      pkt.push_back(8'hAA); pkt.push_back(8'hBB);
   endtask

   task automatic check_initial(input string tag);
      check({tag, ".hv_idx"}, 160'(hv_idx), 160'd25);
      check({tag, ".hv_n"}, 160'(hv_n), 160'd1);
      check({tag, ".err_n"}, 160'(err_n), 160'd0);
      check({tag, ".busy_pl"}, 160'(busy_after_hv), 160'd1);
      check({tag, ".long"}, 160'(hdr_long), 160'd1);
      check({tag, ".type"}, 160'(hdr_type), 160'd0);
      check({tag, ".pn_len"}, 160'(pn_len), 160'd3);
      check({tag, ".dcid_len"}, 160'(dcid_len), 160'd8);
      check({tag, ".scid_len"}, 160'(scid_len), 160'd8);
      check({tag, ".dcid"}, dcid, {64'h1112131415161718, 96'd0});
      check({tag, ".scid"}, scid, {64'h2122232425262728, 96'd0});
      check({tag, ".tok"}, 160'(token_len), 160'd0);
      check({tag, ".paylen"}, 160'(payload_len), 160'd300);
      check({tag, ".idle"}, 160'(busy), 160'd0);
   endtask

   initial begin
      #12;
      check("rst.hdr_valid", 160'(hdr_valid), 160'd0);
      check("rst.err", 160'(err), 160'd0);
      check("rst.busy", 160'(busy), 160'd0);
      check("rst.err_code", 160'(err_code), 160'd0);
      check("rst.dcid", dcid, 160'd0);
      check("rst.paylen", 160'(payload_len), 160'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Initial, no gaps
      build_initial(8'h01);
      send_pkt(0);
      check_initial("init");

      // Wrong version
      build_initial(8'h02);
      send_pkt(0);
      check("ver.err_idx", 160'(err_idx), 160'd4);
      check("ver.err_n", 160'(err_n), 160'd1);
      check("ver.hv_n", 160'(hv_n), 160'd0);
      check("ver.code", 160'(err_code), 160'd2);
      check("ver.busy_err", 160'(busy_at_err), 160'd1);
      check("ver.idle", 160'(busy), 160'd0);

      // DCIL too large, in_last on that byte
      pkt = '{8'hC3, 8'h00, 8'h00, 8'h00, 8'h01, 8'h15};
      send_pkt(0);
      check("dcil.err_idx", 160'(err_idx), 160'd5);
      check("dcil.code", 160'(err_code), 160'd3);
      check("dcil.idle", 160'(busy), 160'd0);

      // Retry
      pkt = '{8'hF0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h04,
              8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
      send_pkt(0);
      check("retry.hv_idx", 160'(hv_idx), 160'd10);
      check("retry.type", 160'(hdr_type), 160'd3);
      check("retry.dcid_len", 160'(dcid_len), 160'd0);
      check("retry.scid_len", 160'(scid_len), 160'd4);
      check("retry.scid", scid, {32'hAABBCCDD, 128'd0});
      check("retry.paylen", 160'(payload_len), 160'd0);
      check("retry.err_code", 160'(err_code), 160'd0);

      // Handshake with 4-byte length var-int
      pkt = '{8'hE1, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00,
              8'h80, 8'h01, 8'h00, 8'h00, 8'h55};
      send_pkt(0);
      check("hs.hv_idx", 160'(hv_idx), 160'd10);
      check("hs.type", 160'(hdr_type), 160'd2);
      check("hs.pn_len", 160'(pn_len), 160'd1);
      check("hs.paylen", 160'(payload_len), 160'd65536);

      // Initial with a 2-byte token
      pkt = '{8'hC0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00,
              8'h02, 8'hAB, 8'hCD, 8'h01, 8'h77};
      send_pkt(0);
      check("tok.hv_idx", 160'(hv_idx), 160'd10);
      check("tok.tok", 160'(token_len), 160'd2);
      check("tok.paylen", 160'(payload_len), 160'd1);

      // Truncated header
      build_initial(8'h01);
      pkt = pkt[0:10];
      send_pkt(0);
      check("trunc.err_idx", 160'(err_idx), 160'd10);
      check("trunc.code", 160'(err_code), 160'd4);
      check("trunc.hv_n", 160'(hv_n), 160'd0);
      check("trunc.idle", 160'(busy), 160'd0);

      // Short header
      pkt = '{8'h41, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h99};
      send_pkt(0);
`ifdef QUIC_SHORT_HDR_EN
      check("short.hv_idx", 160'(hv_idx), 160'd8);
      check("short.long", 160'(hdr_long), 160'd0);
      check("short.dcid_len", 160'(dcid_len), 160'd8);
      check("short.scid_len", 160'(scid_len), 160'd0);
      check("short.dcid", dcid, {64'h0102030405060708, 96'd0});
`else
      check("short.err_idx", 160'(err_idx), 160'd0);
      check("short.code", 160'(err_code), 160'd5);
      check("short.hv_n", 160'(hv_n), 160'd0);
`endif
      check("short.idle", 160'(busy), 160'd0);

      // Initial with 3-cycle gaps
      build_initial(8'h01);
      send_pkt(3);
      check_initial("gap");

      // Reset mid-DCID, then a clean Initial
      build_initial(8'h01);
      pkt = pkt[0:7];
      pkt[7] = 8'h13;
      begin
         logic [7:0] partial[$];
         partial = pkt;
         for (int i = 0; i < partial.size(); i++) begin
            in_valid = 1'b1; in_data = partial[i]; in_last = 1'b0;
            @(posedge clk); #1;
         end
         in_valid = 1'b0;
      end
      check("rstmid.busy_before", 160'(busy), 160'd1);
      rst = 1'b0;
      #2;
      check("rstmid.busy", 160'(busy), 160'd0);
      check("rstmid.dcid_len", 160'(dcid_len), 160'd0);
      check("rstmid.hdr_long", 160'(hdr_long), 160'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      build_initial(8'h01);
      send_pkt(0);
      check_initial("rstmid");

      check("excl", 160'(both_seen), 160'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL timeout: got no finish expected finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
